// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// register file geometry, special-register indices and FSM state codes.
package regfile_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 8;

  // Special registers live at the top of the file; STEPADDR is the first of them.
  localparam int STEPADDR = 21;
  localparam int STEP     = 22;
  localparam int AUC      = 23;
  localparam int RF       = 24;
  localparam int FF       = 25;
  localparam int UF       = 26;
  localparam int RC       = 27;
  localparam int FC       = 28;
  localparam int UC       = 29;
  localparam int DC       = 30;
  localparam int TMP      = 31;

  // Arbiter FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  // Round-robin successor of index g among n requesters.
  function automatic logic [2:0] rr_next(input logic [2:0] g, input int n);
    return (int'(g) == n - 1) ? 3'd0 : g + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans req upward from ptr (wrapping)
// and returns the first set bit as a one-hot grant and a binary index.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      idx,
  output logic            any
);

  // First valid request at or after ptr wins; later candidates are ignored.
  always_comb begin : scan
    int c;
    gnt = '0;
    idx = 3'd0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = 3'(c);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NREQ requesters. Accepts at most one write per cycle via valid/ready and
// presents it on we/dst/data one cycle later.
// Optional feature: define REGFILE_WR_PROT_EN to reject writes from
// requesters other than 0 into the protected range (dst >= PROT_BASE).
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int AW        = RF_AW,
  parameter int DW        = RF_DW,
  parameter int PROT_BASE = STEPADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_dst,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic              freeze,
  output logic              we,
  output logic [AW-1:0]      dst,
  output logic [DW-1:0]      data,
  output logic [2:0]        grant_id,
  output logic [15:0]       wr_cnt,
  output logic              prot_err
);

`ifdef REGFILE_WR_PROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif
  localparam logic [AW-1:0] PROT_IDX = AW'(PROT_BASE);

  logic [1:0]      state_reg;
  logic [1:0]      state_next;
  logic [2:0]      rr_ptr_reg;
  logic [NREQ-1:0] gnt;
  logic [2:0]      g;
  logic            any;
  logic            can_grant;
  logic [AW-1:0]   sel_dst;
  logic [DW-1:0]   sel_data;
  logic            prot_hit;
  logic            do_write;

  // Grants are blocked during reset and while frozen.
  assign can_grant = rst & ~freeze;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid & {NREQ{can_grant}}),
    .ptr (rr_ptr_reg),
    .gnt (gnt),
    .idx (g),
    .any (any)
  );

  assign req_ready = gnt;

  // One-hot mux of the winner's destination and data.
  always_comb begin
    sel_dst  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_dst  = sel_dst  | req_dst[i*AW +: AW];
        sel_data = sel_data | req_data[i*DW +: DW];
      end
    end
  end

  // A protected hit is still handshaked but never reaches the register file.
  assign prot_hit = PROT_ON && any && (g != 3'd0) && (sel_dst >= PROT_IDX);
  assign do_write = any && !prot_hit;

  // WRITE means a write was issued on the previous edge; freeze overrides.
  always_comb begin
    state_next = ST_IDLE;
    if (freeze)        state_next = ST_FROZEN;
    else if (do_write) state_next = ST_WRITE;
  end

  assign we = (state_reg == ST_WRITE);

  // Output registers, round-robin pointer, counter and error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= 3'd0;
      dst        <= '0;
      data       <= '0;
      grant_id   <= 3'd0;
      wr_cnt     <= 16'd0;
      prot_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      prot_err  <= prot_hit;
      if (any) begin
        rr_ptr_reg <= rr_next(g, NREQ);
        grant_id   <= g;
      end
      if (do_write) begin
        dst  <= sel_dst;
        data <= sel_data;
        if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

endmodule
